// File: rtl/aer_spike_rx_pkg.sv
// Shared definitions for the AER spike receiver.
//   - Packet field positions: [31:24] destination X, [23:16] destination Y,
//     [15:0] axon index.
//   - FSM state enumeration used by aer_spike_rx.
//   - Width of the saturating drop counter.
package aer_spike_rx_pkg;

  localparam int unsigned DST_X_MSB = 31;
  localparam int unsigned DST_X_LSB = 24;
  localparam int unsigned DST_Y_MSB = 23;
  localparam int unsigned DST_Y_LSB = 16;
  localparam int unsigned AXON_MSB  = 15;
  localparam int unsigned AXON_LSB  = 0;

  localparam int unsigned DROP_CNT_WIDTH = 8;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    SWAP  = 2'd2
  } state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers for full/empty disambiguation.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset (clears pointers only)
//   push, wdata  - write request and data (ignored when full)
//   pop, rdata   - read request (ignored when empty); rdata shows the head entry
//   full, empty  - status flags
//   count        - number of stored entries
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic             do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Full when the pointers address the same slot but are one lap apart.
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty = (wptr_q == rptr_q);
  assign count = wptr_q - rptr_q;
  assign rdata = mem[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage needs no reset: entries are only visible between valid pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/aer_spike_rx.sv
// AER spike receiver: accepts routed packets into a FIFO, filters them by
// destination and axon range, accumulates hits into a spike vector and, at
// each timestep boundary, drains the FIFO and publishes the vector.
// Ports:
//   clk, rst_n              - clock, asynchronous active-low reset
//   pkt_i/pkt_valid_i       - packet from router with valid
//   pkt_ready_o             - high when a packet can be accepted
//   start_i                 - timestep-boundary pulse from the tile scheduler
//   start_o                 - one-cycle start pulse to the neuron core
//   inSpike_o               - spike vector of the last completed timestep
//   drop_cnt_o              - saturating count of discarded packets
//   busy_o                  - high while draining or swapping
module aer_spike_rx
  import aer_spike_rx_pkg::*;
#(
  parameter int unsigned NUM_AXONS          = 2,
  parameter int unsigned AXON_CNT_BIT_WIDTH = 1,
  parameter int unsigned AER_BIT_WIDTH      = 32,
  parameter int unsigned FIFO_DEPTH         = 4,
  parameter logic [7:0]  X_ID               = 8'd1,
  parameter logic [7:0]  Y_ID               = 8'd1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [AER_BIT_WIDTH-1:0]  pkt_i,
  input  logic                      pkt_valid_i,
  output logic                      pkt_ready_o,
  input  logic                      start_i,
  output logic                      start_o,
  output logic [NUM_AXONS-1:0]      inSpike_o,
  output logic [DROP_CNT_WIDTH-1:0] drop_cnt_o,
  output logic                      busy_o
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] CNT_ONE = 1;

  state_e                    state_q, state_d;
  logic [NUM_AXONS-1:0]      acc_q, acc_d;
  logic [NUM_AXONS-1:0]      spike_q, spike_d;
  logic                      start_q, start_d;
  logic [DROP_CNT_WIDTH-1:0] drop_q, drop_d;

  logic [AER_BIT_WIDTH-1:0]  fifo_rdata;
  logic                      fifo_full, fifo_empty;
  logic [PTR_W:0]            fifo_count;
  logic                      push, pop;

  logic [7:0]                dst_x, dst_y;
  logic [15:0]               axon;
  logic [AXON_CNT_BIT_WIDTH-1:0] axon_idx;
  logic                      addr_ok;

  assign pkt_ready_o = !fifo_full && (state_q == ACCUM);
  assign push        = pkt_valid_i && pkt_ready_o;
  assign pop         = !fifo_empty && ((state_q == ACCUM) || (state_q == DRAIN));

  sync_fifo #(
    .WIDTH (AER_BIT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (pkt_i),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Decode the FIFO head.
  assign dst_x    = fifo_rdata[DST_X_MSB:DST_X_LSB];
  assign dst_y    = fifo_rdata[DST_Y_MSB:DST_Y_LSB];
  assign axon     = fifo_rdata[AXON_MSB:AXON_LSB];
  assign axon_idx = axon[AXON_CNT_BIT_WIDTH-1:0];
  assign addr_ok  = (dst_x == X_ID) && (dst_y == Y_ID) && (32'(axon) < NUM_AXONS);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ACCUM: if (start_i) state_d = fifo_empty ? SWAP : DRAIN;
      // Leave on the edge that pops the final entry.
      DRAIN: if (fifo_count <= CNT_ONE) state_d = SWAP;
      SWAP:  state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  always_comb begin
    acc_d   = acc_q;
    spike_d = spike_q;
    start_d = 1'b0;
    drop_d  = drop_q;
    if (state_q == SWAP) begin
      // No pops occur in SWAP, so nothing is lost by clearing here.
      spike_d = acc_q;
      acc_d   = '0;
      start_d = 1'b1;
    end else if (pop) begin
      if (addr_ok) begin
        acc_d[axon_idx] = 1'b1;
      end else if (drop_q != '1) begin
        drop_d = drop_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      spike_q <= '0;
      start_q <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      spike_q <= spike_d;
      start_q <= start_d;
      drop_q  <= drop_d;
    end
  end

  assign start_o    = start_q;
  assign inSpike_o  = spike_q;
  assign drop_cnt_o = drop_q;
  assign busy_o     = (state_q != ACCUM);

endmodule

// File: tb/tb_aer_spike_rx.sv
// Self-checking bench for aer_spike_rx: table of per-timestep packet pairs
// plus hand-written sequences for drain, backpressure, saturation and reset.
// Expected spike vectors are queued when start_i is driven and compared
// whenever start_o is seen.
module tb_aer_spike_rx;

  logic        clk;
  logic        rst_n;
  logic [31:0] pkt_i;
  logic        pkt_valid_i;
  logic        pkt_ready_o;
  logic        start_i;
  logic        start_o;
  logic [1:0]  inSpike_o;
  logic [7:0]  drop_cnt_o;
  logic        busy_o;

  aer_spike_rx dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pkt_i       (pkt_i),
    .pkt_valid_i (pkt_valid_i),
    .pkt_ready_o (pkt_ready_o),
    .start_i     (start_i),
    .start_o     (start_o),
    .inSpike_o   (inSpike_o),
    .drop_cnt_o  (drop_cnt_o),
    .busy_o      (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  spike;
    int          drops;
  } vec_t;

  typedef struct {
    logic [1:0] spike;
    logic [7:0] drop;
  } exp_t;

  vec_t vecs[6];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   n_start = 0;
  int   exp_drop = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int sat_add(input int a, input int b);
    return (a + b > 255) ? 255 : a + b;
  endfunction

  // Advance one clock, sample 1 time unit after the edge, score any start_o.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (start_o === 1'b1) begin
      n_start++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_start_o: got start_o=1 expected no pulse");
      end else begin
        e = sb.pop_front();
        check("sb_inspike", 32'(inSpike_o), 32'(e.spike));
        check("sb_drop", 32'(drop_cnt_o), 32'(e.drop));
      end
    end
  endtask

  task automatic send(input logic [31:0] p);
    int n;
    n = 0;
    pkt_i = p;
    pkt_valid_i = 1'b1;
    while (pkt_ready_o !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (pkt_ready_o !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got pkt_ready_o=%b expected 1", pkt_ready_o);
    end
    tick();
    pkt_valid_i = 1'b0;
  endtask

  task automatic push_exp(input logic [1:0] spike);
    exp_t e;
    e.spike = spike;
    e.drop  = 8'(exp_drop);
    sb.push_back(e);
  endtask

  task automatic timestep(input logic [1:0] spike);
    start_i = 1'b1;
    push_exp(spike);
    tick();
    start_i = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    int accepts;
    int starts_before;
    logic hs;

    vecs[0] = '{a: 32'h0101_0001, b: 32'h0101_0001, spike: 2'b10, drops: 0};
    vecs[1] = '{a: 32'h0201_0000, b: 32'h0101_0005, spike: 2'b00, drops: 2};
    vecs[2] = '{a: 32'h0101_0000, b: 32'h0101_0001, spike: 2'b11, drops: 0};
    vecs[3] = '{a: 32'h0102_0000, b: 32'h0101_0000, spike: 2'b01, drops: 1};
    vecs[4] = '{a: 32'h0101_0002, b: 32'h0101_FFFF, spike: 2'b00, drops: 2};
    vecs[5] = '{a: 32'h0101_0000, b: 32'h0000_0001, spike: 2'b01, drops: 1};

    rst_n = 1'b0;
    pkt_i = '0;
    pkt_valid_i = 1'b0;
    start_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_start_o", 32'(start_o), 0);
    check("rst_inspike", 32'(inSpike_o), 0);
    check("rst_drop", 32'(drop_cnt_o), 0);
    check("rst_busy", 32'(busy_o), 0);
    rst_n = 1'b1;
    tick();
    check("rst_ready", 32'(pkt_ready_o), 1);

    // Single packet: accepted at edge t, start_o visible after edge t+3.
    send(32'h0101_0001);
    tick();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check("single_no_early_start", 32'(start_o), 0);
    check("single_busy_swap", 32'(busy_o), 1);
    push_exp(2'b10);
    tick();
    check("single_start_o", 32'(start_o), 1);
    check("single_inspike", 32'(inSpike_o), 2'b10);
    tick();
    check("single_start_one_cycle", 32'(start_o), 0);
    check("single_inspike_hold", 32'(inSpike_o), 2'b10);

    // Table-driven timesteps.
    for (int i = 0; i < 6; i++) begin
      send(vecs[i].a);
      send(vecs[i].b);
      repeat (3) tick();
      exp_drop = sat_add(exp_drop, vecs[i].drops);
      check("tbl_drop", 32'(drop_cnt_o), 32'(exp_drop));
      timestep(vecs[i].spike);
    end

    // Drain: four packets back to back, start_i with the last push and held
    // through DRAIN (must be ignored).
    send(32'h0101_0000);
    send(32'h0101_0001);
    send(32'h0101_0000);
    pkt_i = 32'h0101_0001;
    pkt_valid_i = 1'b1;
    start_i = 1'b1;
    tick();
    pkt_valid_i = 1'b0;
    check("drain_ready", 32'(pkt_ready_o), 0);
    check("drain_busy", 32'(busy_o), 1);
    push_exp(2'b11);
    tick();
    start_i = 1'b0;
    check("swap_ready", 32'(pkt_ready_o), 0);
    check("swap_busy", 32'(busy_o), 1);
    check("swap_no_start", 32'(start_o), 0);
    tick();
    check("drain_start_o", 32'(start_o), 1);
    check("drain_inspike", 32'(inSpike_o), 2'b11);
    check("drain_idle", 32'(busy_o), 0);
    repeat (3) tick();

    // Backpressure: hold a packet valid for 8 cycles from DRAIN onward.
    send(32'h0101_0001);
    send(32'h0101_0001);
    pkt_i = 32'h0101_0001;
    pkt_valid_i = 1'b1;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    push_exp(2'b10);
    pkt_i = 32'h0101_0000;
    pkt_valid_i = 1'b1;
    accepts = 0;
    for (int i = 0; i < 8; i++) begin
      hs = pkt_valid_i && pkt_ready_o;
      if (pkt_valid_i) check("bp_no_accept_busy", 32'(hs && busy_o), 0);
      tick();
      if (hs) begin
        accepts++;
        pkt_valid_i = 1'b0;
      end
    end
    pkt_valid_i = 1'b0;
    check("bp_accepts", 32'(accepts), 1);
    repeat (2) tick();
    timestep(2'b01);

    // Saturation: 300 bad packets.
    for (int i = 0; i < 300; i++) send(32'h0201_0000);
    repeat (3) tick();
    exp_drop = sat_add(exp_drop, 300);
    check("sat_drop", 32'(drop_cnt_o), 32'(exp_drop));
    check("sat_drop_255", 32'(drop_cnt_o), 255);

    // start_i held into SWAP must yield only one start_o.
    starts_before = n_start;
    start_i = 1'b1;
    push_exp(2'b00);
    tick();
    tick();
    start_i = 1'b0;
    repeat (6) tick();
    check("swap_ignore_one_start", 32'(n_start - starts_before), 1);
    check("swap_ignore_drop", 32'(drop_cnt_o), 255);

    // Reset mid-DRAIN.
    send(32'h0101_0000);
    pkt_i = 32'h0101_0001;
    pkt_valid_i = 1'b1;
    start_i = 1'b1;
    tick();
    pkt_valid_i = 1'b0;
    start_i = 1'b0;
    check("rd_in_drain", 32'(busy_o), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rd_start_o", 32'(start_o), 0);
    check("rd_inspike", 32'(inSpike_o), 0);
    check("rd_drop", 32'(drop_cnt_o), 0);
    check("rd_busy", 32'(busy_o), 0);
    exp_drop = 0;
    tick();
    tick();
    rst_n = 1'b1;
    check("rd_ready_after", 32'(pkt_ready_o), 1);
    starts_before = n_start;
    repeat (6) tick();
    check("rd_no_start", 32'(n_start - starts_before), 0);
    timestep(2'b00);

    check("sb_empty", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
